fetch_unit: RTL

//  Instruction-fetch stage feeding the IF/ID pipeline register (regs_IF_ID).
//  - Holds the PC and issues one-word requests to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned words in a 2-entry FIFO.
//  - Drives IF/ID in/wr_allow/flush, honouring hazard stalls and branch/jump redirects.
//  - One clock; reset is asynchronous and active-low (clk, rst_n).
//  - All state updates on posedge clk. IF/ID samples on negedge, so outputs are stable half a cycle before capture.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0004;

    // Instruction field positions
    localparam int unsigned NmeMsb = 31;
    localparam int unsigned NmeLsb = 30;
    localparam int unsigned RdMsb  = 29;
    localparam int unsigned RdLsb  = 26;
    localparam int unsigned Rs1Msb = 25;
    localparam int unsigned Rs1Lsb = 22;
    localparam int unsigned Rs2Msb = 21;
    localparam int unsigned Rs2Lsb = 18;
    localparam int unsigned OpcMsb = 2;
    localparam int unsigned OpcLsb = 0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StHold,
        StDiscard
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with clear, count, full and empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  fetch_entry_t    wdata_i,
    output fetch_entry_t    rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    fetch_entry_t           mem_q [Depth];
    logic [AddrW-1:0]       wptr_q, rptr_q;
    logic [CntW-1:0]        cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AddrW'(1);
            if (pop_i)  rptr_q <= rptr_q + AddrW'(1);
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset: the head is only observed when the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !clear_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/gnt/rvalid memory handshake, 2-entry buffer, IF/ID drive.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_out_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        wr_allow_o,
    output logic        flush_o
);

    localparam int unsigned     CntW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [31:0]     pc_q, pc_d, req_pc_q, req_pc_d;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CntW-1:0] fifo_count, occ_after_push;
    fetch_entry_t    fifo_head, fifo_wdata;

    assign fifo_pop       = !fifo_empty && !stall_i && !redirect_en_i;
    assign occ_after_push = fifo_count + CntW'(1) - CntW'(fifo_pop);
    assign fifo_wdata     = '{pc: req_pc_q, instr: imem_rdata_i};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        fifo_push = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_gnt_i) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'(PC_STEP);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (imem_rvalid_i) begin
                    fifo_push = 1'b1;
                    state_d   = (occ_after_push < DepthCnt) ? StReq : StHold;
                end
            end
            StHold:    if (!fifo_full || fifo_pop) state_d = StReq;
            StDiscard: if (imem_rvalid_i) state_d = StReq;
            default:   state_d = StIdle;
        endcase

        // A redirect squashes everything younger; a granted request must still drain its rvalid.
        if (redirect_en_i) begin
            fifo_push = 1'b0;
            pc_d      = align_pc(redirect_pc_i);
            unique case (state_q)
                StReq:     state_d = imem_gnt_i ? StDiscard : StReq;
                StResp:    state_d = imem_rvalid_i ? StReq : StDiscard;
                StDiscard: state_d = imem_rvalid_i ? StReq : StDiscard;
                default:   state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (redirect_en_i),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_req_o    = (state_q == StReq);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_out_o   = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_head.pc;
    assign wr_allow_o    = fifo_pop;
    // Empty and not stalled: inject a NOP bubble rather than re-issue stale IF/ID contents.
    assign flush_o       = redirect_en_i || (fifo_empty && !stall_i);

endmodule
